// File: rtl/systolic_frame_sched.sv
// Frame scheduler for a chain of 4-bit-serial systolic tiles: queue, nibble serializer, return deserializer, flush/drain.
// Optional returned-ctrl consistency check enabled by defining SYSCTL_CTRL_CHECK_EN.
module systolic_frame_sched #(
    parameter int DEPTH = 4,
    parameter int CHAIN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_row,
    input  logic [15:0] in_col,
    input  logic [7:0]  in_ctrl,
    output logic [3:0]  out_row_nib,
    output logic [3:0]  out_col_nib,
    output logic        out_row_ctrl,
    output logic        out_col_ctrl,
    input  logic [3:0]  ret_row_nib,
    input  logic [3:0]  ret_col_nib,
    input  logic        ret_row_ctrl,
    input  logic        ret_col_ctrl,
    output logic        res_valid,
    output logic [15:0] res_row,
    output logic [15:0] res_col,
    output logic [7:0]  res_ctrl,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic        frame_start,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, WAIT = 2'd2} state_t;

    logic [39:0]   mem_q [DEPTH];
    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [15:0]   row_sh_q, row_sh_d, col_sh_q, col_sh_d;
    logic [3:0]    rctl_sh_q, rctl_sh_d, cctl_sh_q, cctl_sh_d;
    logic [CHAIN:0] pipe_q, pipe_d;
    logic [11:0]   ret_row_sh_q, ret_row_sh_d, ret_col_sh_q, ret_col_sh_d;
    logic [2:0]    ret_rctl_sh_q, ret_rctl_sh_d, ret_cctl_sh_q, ret_cctl_sh_d;
    logic          in_ready_q, in_ready_d, res_valid_q, res_valid_d;
    logic [15:0]   res_row_q, res_row_d, res_col_q, res_col_d;
    logic [7:0]    res_ctrl_q, res_ctrl_d;
    logic          busy_q, busy_d, done_q, done_d, frame_start_q, frame_start_d;

    logic          frame_edge_s, empty_s, empty_d_s, full_d_s, push_s, pop_s;
    logic [39:0]   head_s;
    logic [15:0]   ret_row_word_s, ret_col_word_s;
    logic [3:0]    ret_rctl_word_s, ret_cctl_word_s;
    logic [7:0]    ret_ctrl_s;

    // Next-state logic for queue, serializer, deserializer, in-flight pipe and drain sequencing.
    always_comb begin
        frame_edge_s  = (cnt_q == 2'd3);
        empty_s       = (wr_ptr_q == rd_ptr_q);
        push_s        = in_valid && in_ready_q;
        pop_s         = frame_edge_s && !empty_s;
        head_s        = mem_q[rd_ptr_q[AW-1:0]];
        cnt_d         = cnt_q + 2'd1;
        wr_ptr_d      = wr_ptr_q + PW'(push_s);
        rd_ptr_d      = rd_ptr_q + PW'(pop_s);
        empty_d_s     = (wr_ptr_d == rd_ptr_d);
        full_d_s      = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

        // A frame edge reloads the serializer (zeros for an idle frame); otherwise shift MSB-first.
        row_sh_d  = frame_edge_s ? (pop_s ? head_s[31:16] : 16'd0) : {row_sh_q[11:0], 4'd0};
        col_sh_d  = frame_edge_s ? (pop_s ? head_s[15:0]  : 16'd0) : {col_sh_q[11:0], 4'd0};
        rctl_sh_d = frame_edge_s ? (pop_s ? head_s[35:32] : 4'd0)  : {rctl_sh_q[2:0], 1'b0};
        cctl_sh_d = frame_edge_s ? (pop_s ? head_s[39:36] : 4'd0)  : {cctl_sh_q[2:0], 1'b0};
        pipe_d    = frame_edge_s ? {pipe_q[CHAIN-1:0], pop_s} : pipe_q;

        ret_row_word_s  = {ret_row_sh_q, ret_row_nib};
        ret_col_word_s  = {ret_col_sh_q, ret_col_nib};
        ret_rctl_word_s = {ret_rctl_sh_q, ret_row_ctrl};
        ret_cctl_word_s = {ret_cctl_sh_q, ret_col_ctrl};
        ret_ctrl_s      = {ret_cctl_word_s, ret_rctl_word_s};
        ret_row_sh_d    = ret_row_word_s[11:0];
        ret_col_sh_d    = ret_col_word_s[11:0];
        ret_rctl_sh_d   = ret_rctl_word_s[2:0];
        ret_cctl_sh_d   = ret_cctl_word_s[2:0];

        res_valid_d = frame_edge_s && pipe_q[CHAIN];
        res_row_d   = res_valid_d ? ret_row_word_s : res_row_q;
        res_col_d   = res_valid_d ? ret_col_word_s : res_col_q;
        res_ctrl_d  = res_valid_d ? ret_ctrl_s     : res_ctrl_q;

        done_d = 1'b0;
        case (state_q)
            RUN: begin
                if (flush) state_d = DRAIN;
                else       state_d = RUN;
            end
            DRAIN: begin
                if (frame_edge_s && empty_d_s) state_d = WAIT;
                else                           state_d = DRAIN;
            end
            WAIT: begin
                if (frame_edge_s && (pipe_d == {(CHAIN+1){1'b0}})) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            default: state_d = RUN;
        endcase

        in_ready_d    = (state_d == RUN) && !full_d_s;
        busy_d        = !empty_d_s || (pipe_d != {(CHAIN+1){1'b0}}) || (state_d != RUN);
        frame_start_d = (cnt_d == 2'd0);
    end

    // Queue storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) mem_q[wr_ptr_q[AW-1:0]] <= {in_ctrl, in_row, in_col};
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            cnt_q         <= 2'd0;
            wr_ptr_q      <= {PW{1'b0}};
            rd_ptr_q      <= {PW{1'b0}};
            row_sh_q      <= 16'd0;
            col_sh_q      <= 16'd0;
            rctl_sh_q     <= 4'd0;
            cctl_sh_q     <= 4'd0;
            pipe_q        <= {(CHAIN+1){1'b0}};
            ret_row_sh_q  <= 12'd0;
            ret_col_sh_q  <= 12'd0;
            ret_rctl_sh_q <= 3'd0;
            ret_cctl_sh_q <= 3'd0;
            in_ready_q    <= 1'b1;
            res_valid_q   <= 1'b0;
            res_row_q     <= 16'd0;
            res_col_q     <= 16'd0;
            res_ctrl_q    <= 8'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            frame_start_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            row_sh_q      <= row_sh_d;
            col_sh_q      <= col_sh_d;
            rctl_sh_q     <= rctl_sh_d;
            cctl_sh_q     <= cctl_sh_d;
            pipe_q        <= pipe_d;
            ret_row_sh_q  <= ret_row_sh_d;
            ret_col_sh_q  <= ret_col_sh_d;
            ret_rctl_sh_q <= ret_rctl_sh_d;
            ret_cctl_sh_q <= ret_cctl_sh_d;
            in_ready_q    <= in_ready_d;
            res_valid_q   <= res_valid_d;
            res_row_q     <= res_row_d;
            res_col_q     <= res_col_d;
            res_ctrl_q    <= res_ctrl_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_row_nib  = row_sh_q[15:12];
    assign out_col_nib  = col_sh_q[15:12];
    assign out_row_ctrl = rctl_sh_q[3];
    assign out_col_ctrl = cctl_sh_q[3];
    assign res_valid    = res_valid_q;
    assign res_row      = res_row_q;
    assign res_col      = res_col_q;
    assign res_ctrl     = res_ctrl_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign frame_start  = frame_start_q;

`ifdef SYSCTL_CTRL_CHECK_EN
    logic [7:0] hist_q [CHAIN+1];
    logic [7:0] hist_d [CHAIN+1];
    logic       err_q, err_d;

    // Issued-ctrl history travels with the valid pipe; its tail is the ctrl expected back.
    always_comb begin
        hist_d = hist_q;
        err_d  = err_q;
        if (frame_edge_s) begin
            hist_d[0] = pop_s ? head_s[39:32] : 8'd0;
            for (int i = 1; i <= CHAIN; i++) hist_d[i] = hist_q[i-1];
            if (pipe_q[CHAIN] && (ret_ctrl_s != hist_q[CHAIN])) err_d = 1'b1;
            else                                                 err_d = err_q;
        end else begin
            err_d = err_q;
        end
    end

    // Sticky error and history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            for (int i = 0; i <= CHAIN; i++) hist_q[i] <= 8'd0;
        end else begin
            err_q  <= err_d;
            hist_q <= hist_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_systolic_frame_sched.sv
// Randomized self-checking bench for systolic_frame_sched with a frame-level reference model and a tile-chain delay model.
module tb_systolic_frame_sched;
    localparam int DEPTH = 4;
    localparam int CHAIN = 1;
    localparam int DL    = 4 * CHAIN;

    logic        clk, rst_n, in_valid, in_ready, flush, busy, done, frame_start, err, res_valid;
    logic [15:0] in_row, in_col, res_row, res_col;
    logic [7:0]  in_ctrl, res_ctrl;
    logic [3:0]  out_row_nib, out_col_nib, ret_row_nib, ret_col_nib;
    logic        out_row_ctrl, out_col_ctrl, ret_row_ctrl, ret_col_ctrl;
    logic        corrupt;

    systolic_frame_sched #(.DEPTH(DEPTH), .CHAIN(CHAIN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_row(in_row), .in_col(in_col), .in_ctrl(in_ctrl),
        .out_row_nib(out_row_nib), .out_col_nib(out_col_nib),
        .out_row_ctrl(out_row_ctrl), .out_col_ctrl(out_col_ctrl),
        .ret_row_nib(ret_row_nib), .ret_col_nib(ret_col_nib),
        .ret_row_ctrl(ret_row_ctrl), .ret_col_ctrl(ret_col_ctrl),
        .res_valid(res_valid), .res_row(res_row), .res_col(res_col), .res_ctrl(res_ctrl),
        .flush(flush), .busy(busy), .done(done), .frame_start(frame_start), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tile chain: every tile delays the pins by one 4-cycle frame.
    logic [3:0] dl_rn [DL];
    logic [3:0] dl_cn [DL];
    logic       dl_rc [DL];
    logic       dl_cc [DL];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DL; i++) begin
                dl_rn[i] <= 4'd0; dl_cn[i] <= 4'd0; dl_rc[i] <= 1'b0; dl_cc[i] <= 1'b0;
            end
        end else begin
            dl_rn[0] <= out_row_nib;
            dl_cn[0] <= out_col_nib;
            dl_rc[0] <= out_row_ctrl ^ corrupt;
            dl_cc[0] <= out_col_ctrl;
            for (int i = 1; i < DL; i++) begin
                dl_rn[i] <= dl_rn[i-1]; dl_cn[i] <= dl_cn[i-1];
                dl_rc[i] <= dl_rc[i-1]; dl_cc[i] <= dl_cc[i-1];
            end
        end
    end
    assign ret_row_nib  = dl_rn[DL-1];
    assign ret_col_nib  = dl_cn[DL-1];
    assign ret_row_ctrl = dl_rc[DL-1];
    assign ret_col_ctrl = dl_cc[DL-1];

    // Reference model state: pending queue, in-flight results with due cycle, current output frame.
    typedef struct {
        int          due;
        logic [39:0] data;
        bit          bad;
    } fl_t;

    logic [39:0] mq[$];
    fl_t         fl[$];
    logic [39:0] cur;
    int          mstate;   // 0 accepting, 1 draining queue, 2 waiting for chain to empty
    bit          m_ready, last_push, err_exp;
    int          done_at, cyc;
    int          n_chk, n_pass;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        mq.delete();
        fl.delete();
        cur = 40'd0; mstate = 0; m_ready = 1'b1; done_at = -1; err_exp = 1'b0; cyc = 0;
    endtask

    task automatic check_cycle();
        logic [39:0] e;
        logic [15:0] w;
        bit rv;
        int ph;
        e = 40'd0; rv = 1'b0; ph = cyc % 4;
        if (fl.size() > 0 && fl[0].due == cyc) begin
            rv = 1'b1;
            e  = fl[0].data;
            if (fl[0].bad) begin
                e[35] = ~e[35];
`ifdef SYSCTL_CTRL_CHECK_EN
                err_exp = 1'b1;
`endif
            end
            void'(fl.pop_front());
        end
        chk("res_valid", res_valid, rv);
        if (rv) begin
            chk("res_row", res_row, e[31:16]);
            chk("res_col", res_col, e[15:0]);
            chk("res_ctrl", res_ctrl, e[39:32]);
        end
        chk("done", done, done_at == cyc);
        chk("busy", busy, (mq.size() > 0) || (fl.size() > 0) || (mstate != 0));
        chk("in_ready", in_ready, m_ready);
        chk("frame_start", frame_start, ph == 0);
        w = cur[31:16] >> (12 - 4 * ph);
        chk("out_row_nib", out_row_nib, w[3:0]);
        w = cur[15:0] >> (12 - 4 * ph);
        chk("out_col_nib", out_col_nib, w[3:0]);
        chk("out_row_ctrl", out_row_ctrl, cur[35-ph]);
        chk("out_col_ctrl", out_col_ctrl, cur[39-ph]);
        chk("err", err, err_exp);
    endtask

    task automatic step();
        int ph;
        bit pend;
        @(posedge clk);
        ph = cyc % 4;
        last_push = in_valid && m_ready;
        if (ph == 3) begin
            if (mq.size() > 0) begin
                cur = mq.pop_front();
                fl.push_back('{due: cyc + 4 * CHAIN + 5, data: cur, bad: 1'b0});
            end else begin
                cur = 40'd0;
            end
        end
        if (corrupt && ph == 0 && fl.size() > 0 && fl[fl.size()-1].due == cyc + 4 * CHAIN + 4)
            fl[fl.size()-1].bad = 1'b1;
        if (last_push) mq.push_back({in_ctrl, in_row, in_col});
        case (mstate)
            0: if (flush) mstate = 1;
            1: if (ph == 3 && mq.size() == 0) mstate = 2;
            2: if (ph == 3) begin
                   pend = 1'b0;
                   foreach (fl[i]) if (fl[i].due > cyc + 1) pend = 1'b1;
                   if (!pend) begin mstate = 0; done_at = cyc + 1; end
               end
            default: mstate = 0;
        endcase
        m_ready = (mstate == 0) && (mq.size() < DEPTH);
        cyc++;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; flush = 1'b0;
        repeat (n) step();
    endtask

    task automatic push_one(input logic [15:0] r, input logic [15:0] c, input logic [7:0] k, input bit f);
        int t;
        t = 0;
        in_valid = 1'b1; in_row = r; in_col = c; in_ctrl = k; flush = 1'b0;
        while (!m_ready && t < 64) begin step(); t++; end
        flush = f;
        step();
        chk("push_accepted", last_push, 1'b1);
        in_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        int got, t;
        bit hit;
        n_chk = 0; n_pass = 0;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; corrupt = 1'b0;
        in_row = 16'd0; in_col = 16'd0; in_ctrl = 8'd0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_frame_start", frame_start, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_row", out_row_nib, 4'd0);
        rst_n = 1'b1;
        model_reset();
        check_cycle();
        idle(12);

        push_one(16'hA5C3, 16'h1234, 8'h9F, 1'b0);
        idle(16);

        // Hold valid until six pairs are accepted so the queue fills.
        got = 0; t = 0;
        while (got < 6 && t < 200) begin
            in_valid = 1'b1; in_row = 16'($urandom); in_col = 16'($urandom); in_ctrl = 8'($urandom);
            step();
            if (last_push) got++;
            t++;
        end
        chk("burst_accepted", got, 6);
        idle(36);

        push_one(16'h1111, 16'h2222, 8'h33, 1'b0);
        push_one(16'h4444, 16'h5555, 8'h66, 1'b0);
        push_one(16'h7777, 16'h8888, 8'h99, 1'b1);
        idle(30);

        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_row = 16'($urandom); in_col = 16'($urandom); in_ctrl = 8'($urandom);
            flush = ($urandom_range(0, 39) == 0);
            step();
        end
        idle(40);

        // Flip one returned row-ctrl bit of a real frame.
        push_one(16'hBEEF, 16'hCAFE, 8'h5A, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (fl.size() > 0 && cyc % 4 == 0 && fl[fl.size()-1].due == cyc + 4 * CHAIN + 4) begin
                corrupt = 1'b1;
                step();
                corrupt = 1'b0;
                hit = 1'b1;
            end else begin
                step();
            end
        end
        chk("corrupt_injected", hit, 1'b1);
        idle(20);

        // Asynchronous reset mid-frame with pairs still queued.
        push_one(16'h0F0F, 16'hF0F0, 8'hC3, 1'b0);
        push_one(16'h1357, 16'h2468, 8'h7E, 1'b0);
        push_one(16'h9ABC, 16'hDEF0, 8'h81, 1'b0);
        t = 0;
        while (!(mq.size() == 2 && cyc % 4 != 0) && t < 20) begin step(); t++; end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_row", out_row_nib, 4'd0);
        chk("mid_rst_out_col", out_col_nib, 4'd0);
        chk("mid_rst_res_valid", res_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_frame_start", frame_start, 1'b1);
        chk("mid_rst_err", err, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_cycle();
        idle(24);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
